// File: rtl/sram_access_ctrl.sv
// Request/response front end for a 256x32 single-port SRAM: optional zero-fill after
// reset, single-cycle full-word writes, read-modify-write for partial strobes.
module sram_access_ctrl #(
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_strb,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        init_done,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [7:0]  sram_a,
    output logic [31:0] sram_d,
    input  logic [31:0] sram_q
);

    typedef enum logic [1:0] {
        st_init,
        st_idle,
        st_rmw_wr
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  fill_cnt;
    logic        init_done_q;
    logic        pend;
    logic [7:0]  rmw_addr;
    logic [3:0]  rmw_strb;
    logic [31:0] rmw_wdata;
    logic [7:0]  a_hold;
    logic [31:0] d_hold;
    logic        accept;
    logic        strb_full;
    logic        strb_none;
    logic [31:0] byte_mask;
    logic [31:0] merged;

    // Without a fill there is nothing to wait for, so readiness follows reset directly.
    assign init_done = INIT_ZERO ? init_done_q : !rst;

    assign req_ready = (state == st_idle) && init_done && !pend && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign strb_full = (req_strb == 4'hF);
    assign strb_none = (req_strb == 4'h0);

    assign byte_mask = {{8{rmw_strb[3]}}, {8{rmw_strb[2]}}, {8{rmw_strb[1]}}, {8{rmw_strb[0]}}};
    assign merged    = (rmw_wdata & byte_mask) | (sram_q & ~byte_mask);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_ZERO) state <= st_init;
            else           state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            st_init:   if (fill_cnt == 8'hFF) state_nxt = st_idle;
            st_idle:   if (accept && req_we && !strb_full && !strb_none) state_nxt = st_rmw_wr;
            st_rmw_wr: state_nxt = st_idle;
            default:   state_nxt = st_idle;
        endcase
    end

    // Address/data hold their last driven value whenever no access is issued.
    always_comb begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
        sram_a   = a_hold;
        sram_d   = d_hold;
        if (!rst) begin
            case (state)
                st_init: begin
                    sram_cen = 1'b1;
                    sram_wen = 1'b1;
                    sram_a   = fill_cnt;
                    sram_d   = 32'h0;
                end
                st_idle: begin
                    if (accept && !(req_we && strb_none)) begin
                        sram_cen = 1'b1;
                        sram_a   = req_addr;
                        if (req_we && strb_full) begin
                            sram_wen = 1'b1;
                            sram_d   = req_wdata;
                        end
                    end
                end
                st_rmw_wr: begin
                    sram_cen = 1'b1;
                    sram_wen = 1'b1;
                    sram_a   = rmw_addr;
                    sram_d   = merged;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt    <= 8'h0;
            init_done_q <= 1'b0;
            pend        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            rmw_addr    <= 8'h0;
            rmw_strb    <= 4'h0;
            rmw_wdata   <= 32'h0;
            a_hold      <= 8'h0;
            d_hold      <= 32'h0;
        end else begin
            a_hold <= sram_a;
            d_hold <= sram_d;

            // Saturate so the fill can never restart on its own.
            if (state == st_init && fill_cnt != 8'hFF)
                fill_cnt <= fill_cnt + 8'd1;
            if (state == st_init && state_nxt == st_idle)
                init_done_q <= 1'b1;

            pend <= accept && !req_we;

            if (accept && req_we) begin
                rmw_addr  <= req_addr;
                rmw_strb  <= req_strb;
                rmw_wdata <= req_wdata;
            end

            if (pend) begin
                resp_rdata <= sram_q;
                resp_valid <= 1'b1;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed plus randomized bench for sram_access_ctrl, with a behavioural SRAM and a
// word-array reference model of the memory contents.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_strb;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        init_done;
    logic        sram_cen;
    logic        sram_wen;
    logic [7:0]  sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem  [256];
    logic [31:0] sram_mem [256];

    sram_access_ctrl #(.INIT_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_strb   (req_strb),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: read data is only trustworthy the cycle after a read.
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) begin
                sram_mem[sram_a] <= sram_d;
                sram_q           <= $urandom;
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 40) begin
            tick();
            if (n >= 2) resp_ready = 1'b1;
            #1;
            n++;
        end
        check({tag, "_ready"}, req_ready, 1'b1);
    endtask

    task automatic check_fill();
        for (int i = 0; i < 256; i++) begin
            check($sformatf("fill_%0d", i),
                  {init_done, req_ready, sram_cen, sram_wen, sram_a, sram_d},
                  {1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 32'h0});
            tick();
            #1;
        end
        check("fill_done", {init_done, req_ready, sram_cen, sram_wen}, 4'b1100);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        logic [31:0] expd;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        expd = (ref_mem[addr] & ~mask) | (data & mask);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_strb  = strb;
        #1;
        wait_ready("wr");
        if (strb == 4'hF)
            check("wr_full_issue", {sram_cen, sram_wen, sram_a, sram_d}, {2'b11, addr, data});
        else if (strb == 4'h0)
            check("wr_none_issue", {sram_cen, sram_wen}, 2'b00);
        else
            check("wr_rmw_read", {sram_cen, sram_wen, sram_a}, {2'b10, addr});
        tick();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        #1;
        if (strb != 4'hF && strb != 4'h0) begin
            check("wr_rmw_write", {req_ready, sram_cen, sram_wen, sram_a, sram_d},
                  {3'b011, addr, expd});
            tick();
            #1;
        end else begin
            check("wr_after", {sram_cen, sram_wen}, 2'b00);
        end
        ref_mem[addr] = expd;
    endtask

    task automatic do_read(input logic [7:0] addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_strb  = 4'($urandom);
        req_wdata = $urandom;
        #1;
        wait_ready("rd");
        check("rd_issue", {sram_cen, sram_wen, sram_a}, {2'b10, addr});
        tick();
        req_valid = 1'b0;
        #1;
        check("rd_pend", {req_ready, resp_valid, sram_cen}, 3'b000);
        tick();
        #1;
        check("rd_data", {resp_valid, resp_rdata}, {1'b1, ref_mem[addr]});
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_strb   = 4'h0;
        req_addr   = 8'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs",
              {req_ready, resp_valid, resp_rdata, init_done, sram_cen, sram_wen, sram_a, sram_d},
              64'h0);

        rst = 1'b0;
        #1;
        check_fill();

        // Full-word write then read back.
        do_write(8'h10, 32'hDEADBEEF, 4'hF);
        do_read(8'h10);
        check("deadbeef_literal", resp_rdata, 32'hDEADBEEF);

        // Partial-strobe merge.
        do_write(8'h10, 32'h11223344, 4'b0101);
        do_read(8'h10);
        check("merge_literal", resp_rdata, 32'hDE22BE44);

        // Zero strobe leaves memory alone; then full write at another address.
        do_write(8'h30, 32'hA5A50F0F, 4'h0);
        do_read(8'h30);
        do_write(8'h30, 32'h0BADF00D, 4'hF);

        // Back-to-back reads under response backpressure.
        resp_ready = 1'b0;
        do_read(8'h10);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h30;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_%0d", k), {req_ready, resp_valid, resp_rdata, sram_cen},
                  {1'b0, 1'b1, 32'hDE22BE44, 1'b0});
            tick();
            #1;
        end
        resp_ready = 1'b1;
        #1;
        check("b2b_accept", {req_ready, sram_cen, sram_wen, sram_a}, {3'b110, 8'h30});
        tick();
        req_valid = 1'b0;
        #1;
        check("b2b_first_taken", resp_valid, 1'b0);
        tick();
        #1;
        check("b2b_second", {resp_valid, resp_rdata}, {1'b1, ref_mem[8'h30]});

        // Randomized traffic against the reference memory.
        for (int n = 0; n < 150; n++) begin
            logic [7:0] addr;
            int         op;
            addr       = 8'($urandom_range(0, 15));
            op         = $urandom_range(0, 3);
            resp_ready = ($urandom_range(0, 3) != 0);
            case (op)
                0, 1: do_read(addr);
                2:    do_write(addr, $urandom, 4'hF);
                default: do_write(addr, $urandom, 4'($urandom));
            endcase
        end
        resp_ready = 1'b1;
        tick();
        #1;
        for (int i = 0; i < 16; i++)
            check($sformatf("mem_%0d", i), sram_mem[i], ref_mem[i]);

        // Reset during the write half of a read-modify-write.
        do_write(8'h20, 32'hCAFEF00D, 4'hF);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 32'h11111111;
        req_strb  = 4'b0011;
        #1;
        wait_ready("rmw_rst");
        check("rmw_rst_read", {sram_cen, sram_wen, sram_a}, {2'b10, 8'h20});
        tick();
        req_valid = 1'b0;
        #1;
        check("rmw_rst_wr_phase", {sram_cen, sram_wen}, 2'b11);
        rst = 1'b1;
        #1;
        check("rst_mid_rmw",
              {req_ready, resp_valid, resp_rdata, init_done, sram_cen, sram_wen, sram_a, sram_d},
              64'h0);
        tick();
        tick();
        #1;
        check("rst_no_write", sram_mem[8'h20], ref_mem[8'h20]);
        rst = 1'b0;
        #1;
        check_fill();
        do_read(8'h20);
        do_read(8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter INIT_ZERO, default 1; 1 = zero-fill all 256 SRAM words after reset, 0 = no fill.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  request accepted when req_valid&&req_ready at a rising edge.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_strb  in  4  byte write strobe, bit i enables byte [8i+7:8i]; ignored for reads.
REQ-008 req_addr  in  8  word address.
REQ-009 req_wdata  in  32  write data.
REQ-010 resp_valid  out  1  read data available.
REQ-011 resp_ready  in  1  consumer takes response when resp_valid&&resp_ready.
REQ-012 resp_rdata  out  32  read data, stable while resp_valid&&!resp_ready.
REQ-013 init_done  out  1  high once the block can accept requests.
REQ-014 sram_cen  out  1  active-high SRAM access enable to the 256x32 single-port SRAM wrapper.
REQ-015 sram_wen  out  1  active-high write enable, meaningful only with sram_cen=1.
REQ-016 sram_a  out  8  SRAM address.
REQ-017 sram_d  out  32  SRAM write data.
REQ-018 sram_q  in  32  SRAM read data: valid the cycle after a cycle with sram_cen=1,sram_wen=0; undefined after any later enabled access.

Function
REQ-019 States: INIT, IDLE, RMW_WR; plus flag pend (read capture due next cycle) and one-entry response buffer.
REQ-020 INIT (INIT_ZERO=1): one write per cycle, sram_cen=1, sram_wen=1, sram_d=0, sram_a counting 0..255; after the address-255 cycle go IDLE, init_done=1 next cycle; counter must not wrap to restart.
REQ-021 INIT_ZERO=0: enter IDLE directly; init_done=1 in first cycle after rst deasserts.
REQ-022 req_ready = (state==IDLE) && init_done && !pend && (!resp_valid || resp_ready); combinational, no dependence on req_valid.
REQ-023 Read accepted in cycle T: sram_cen=1, sram_wen=0, sram_a=req_addr combinationally in T; pend=1 in T+1; sram_q captured into response buffer at end of T+1; resp_valid=1 from T+2.
REQ-024 resp_valid clears on the edge where resp_valid&&resp_ready unless a capture occurs on the same edge, in which case the new data loads and resp_valid stays 1.
REQ-025 Write with req_strb==4'hF accepted in T: single SRAM write in T (sram_a=req_addr, sram_d=req_wdata); stay IDLE; no response generated.
REQ-026 Write with req_strb==4'h0: accepted, no SRAM access, no response.
REQ-027 Write with partial strobe accepted in T: SRAM read of req_addr in T, go RMW_WR; addr, strb, wdata latched.
REQ-028 RMW_WR (T+1): SRAM write to latched addr, sram_d byte i = strb[i] ? wdata byte i : sram_q byte i; return to IDLE at T+2; req_ready=0 in T+1; no response generated.
REQ-029 Requests strictly serialised; at most one outstanding read; sustained read rate one per 2 cycles, full-word write rate one per cycle.
REQ-030 When no access is issued: sram_cen=0, sram_wen=0; sram_a/sram_d don't-care but must not toggle (hold last value).

Reset
REQ-031 While rst=1: req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, pend=0, sram_cen=0, sram_wen=0, sram_a=0, sram_d=0, state=INIT (or IDLE if INIT_ZERO=0).
REQ-032 rst asserted mid-fill, mid-RMW or with a pending response: operation aborted, pending response discarded, fill restarts from address 0 after deassertion.

Verification
REQ-033 Reset release, INIT_ZERO=1 -> exactly 256 write cycles on addr 0..255 with sram_d=0, init_done rises next cycle, req_ready=0 throughout fill.
REQ-034 Write addr 8'h10 data 32'hDEADBEEF strb 4'hF, then read 8'h10 -> one SRAM write cycle; resp_rdata=32'hDEADBEEF with resp_valid two cycles after read acceptance.
REQ-035 After REQ-034, write 8'h10 data 32'h11223344 strb 4'b0101, read 8'h10 -> read-then-write SRAM cycles, resp_rdata=32'hDE22BE44.
REQ-036 Two back-to-back reads with resp_ready=0 for 5 cycles -> second read not accepted until first response taken; first resp_rdata held stable; responses returned in order.
REQ-037 Assert rst during RMW_WR cycle of a partial write to 8'h20 -> no write issued in the reset cycle, all outputs 0, fill restarts at address 0 after deassertion.
